// File: rtl/serial_frame_rx_if.sv
// Parallel output side of the serial frame receiver: one word plus its
// parity flag, moved with a valid/ready handshake.
interface serial_frame_rx_if #(
    parameter int N = 8
);
    logic [N-1:0] out_data;
    logic         out_perr;
    logic         out_valid;
    logic         out_ready;

    // Receiver side drives the word, consumer side drives ready.
    modport master (
        output out_data,
        output out_perr,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_perr,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start(1), N data bits MSB first, even parity,
// stop(0); idle line is 0. Good words land in a one-entry output buffer.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line idle, waiting for a start bit (sin=1)
// DATA   | shifting in the N data bits, running XOR for parity
// PARITY | sampling the parity bit, latching the parity error flag
// STOP   | sampling the stop bit, loading/discarding the word
module serial_frame_rx #(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    serial_frame_rx_if.master rx,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [N-1:0]  acc;
    logic          par_acc;
    logic          perr;
    logic          drain;
    logic          load_word;
    logic          frame_err_set;
    logic          overrun_set;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; STOP always returns to IDLE so a start bit is
    // never detected in the stop-bit cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sin) state_nxt = DATA;
            DATA:    if (cnt == LAST) state_nxt = PARITY;
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state outputs and the stop-bit outcome decode.
    always_comb begin
        busy          = (state != IDLE);
        drain         = rx.out_valid & rx.out_ready;
        load_word     = (state == STOP) & ~sin & (~rx.out_valid | rx.out_ready);
        frame_err_set = (state == STOP) & sin;
        overrun_set   = (state == STOP) & ~sin & rx.out_valid & ~rx.out_ready;
    end

    // Bit counter, shift accumulator and parity tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            par_acc <= 1'b0;
            perr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sin) begin
                        cnt     <= '0;
                        par_acc <= 1'b0;
                    end
                end
                DATA: begin
                    acc     <= {acc[N-2:0], sin};
                    par_acc <= par_acc ^ sin;
                    // Clear on the last bit rather than rely on a power-of-two wrap.
                    if (cnt == LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PARITY: begin
                    perr <= par_acc ^ sin;
                end
                default: begin
                end
            endcase
        end
    end

    // One-entry output buffer plus the registered error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx.out_data  <= '0;
            rx.out_perr  <= 1'b0;
            rx.out_valid <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_err <= frame_err_set;
            overrun   <= overrun_set;
            if (load_word) begin
                rx.out_data  <= acc;
                rx.out_perr  <= perr;
                rx.out_valid <= 1'b1;
            end else if (drain) begin
                rx.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: a frame-level model schedules the outcome of
// every frame it sends and a single process checks the DUT each cycle.
module tb_serial_frame_rx;
    localparam int N = 8;

    typedef struct {
        int           start_e;
        int           done_e;
        logic [N-1:0] word;
        logic         perr;
        logic         stop;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sin = 1'b0;
    logic out_ready = 1'b0;
    logic frame_err;
    logic overrun;
    logic busy;
    logic rand_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    frame_t       sched_q[$];
    logic         m_valid;
    logic [N-1:0] m_data;
    logic         m_perr;
    logic         e_ferr;
    logic         e_ovr;
    logic         e_busy;

    serial_frame_rx_if #(.N(N)) bus ();
    assign bus.out_ready = out_ready;

    serial_frame_rx #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .rx        (bus),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic void model_clear();
        sched_q.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_perr  = 1'b0;
        e_ferr  = 1'b0;
        e_ovr   = 1'b0;
        e_busy  = 1'b0;
    endfunction

    // Model update on each edge, then compare 1 time unit later.
    initial begin
        frame_t f;
        logic   rdy_s;
        logic   drain;
        logic   loaded;
        model_clear();
        forever begin
            @(posedge clk);
            edge_cnt++;
            rdy_s = out_ready;
            if (rst) begin
                model_clear();
            end else begin
                e_ferr = 1'b0;
                e_ovr  = 1'b0;
                drain  = m_valid && rdy_s;
                loaded = 1'b0;
                if (sched_q.size() > 0 && sched_q[0].done_e == edge_cnt) begin
                    f = sched_q.pop_front();
                    if (f.stop) begin
                        e_ferr = 1'b1;
                    end else if (!m_valid || drain) begin
                        m_data  = f.word;
                        m_perr  = f.perr;
                        m_valid = 1'b1;
                        loaded  = 1'b1;
                    end else begin
                        e_ovr = 1'b1;
                    end
                end
                if (drain && !loaded) m_valid = 1'b0;
                e_busy = (sched_q.size() > 0) && (sched_q[0].start_e <= edge_cnt);
            end
            #1;
            check("out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid) begin
                check("out_data", 32'(bus.out_data), 32'(m_data));
                check("out_perr", 32'(bus.out_perr), 32'(m_perr));
            end
            check("frame_err", 32'(frame_err), 32'(e_ferr));
            check("overrun", 32'(overrun), 32'(e_ovr));
            check("busy", 32'(busy), 32'(e_busy));
        end
    end

    // Random consumer back-pressure, enabled only in the random phase.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sched_frame(input logic [N-1:0] w, input logic pbit, input logic sbit, output int done);
        frame_t f;
        f.start_e = edge_cnt + 1;
        f.done_e  = f.start_e + N + 2;
        f.word    = w;
        f.perr    = (^w) ^ pbit;
        f.stop    = sbit;
        sched_q.push_back(f);
        done = f.done_e;
    endtask

    // Drives start, data, parity, stop; returns after driving the stop bit.
    task automatic send_frame(input logic [N-1:0] w, input logic pbit, input logic sbit,
                              input int rdy_stop, output int done);
        @(negedge clk);
        sched_frame(w, pbit, sbit, done);
        sin = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            @(negedge clk);
            sin = w[i];
        end
        @(negedge clk);
        sin = pbit;
        @(negedge clk);
        sin = sbit;
        if (rdy_stop >= 0) out_ready = rdy_stop[0];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sin = 1'b0;
        end
    endtask

    // Returns 2 time units after edge n (after the model compare).
    task automatic goto_edge(input int n);
        while (edge_cnt < n) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    initial begin
        int           done;
        logic [N-1:0] w;
        logic         pbit;
        logic         sbit;

        goto_edge(3);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // 0xA5 with correct parity, consumer ready.
        send_frame(8'hA5, 1'b0, 1'b0, -1, done);
        goto_edge(done - 1);
        check("lat_not_yet", 32'(bus.out_valid), 32'd0);
        goto_edge(done);
        check("a5_valid", 32'(bus.out_valid), 32'd1);
        check("a5_data", 32'(bus.out_data), 32'hA5);
        check("a5_perr", 32'(bus.out_perr), 32'd0);
        idle(1);
        goto_edge(done + 1);
        check("a5_drained", 32'(bus.out_valid), 32'd0);
        idle(2);

        // Same word, wrong parity: delivered with out_perr.
        send_frame(8'hA5, 1'b1, 1'b0, -1, done);
        goto_edge(done);
        check("perr_data", 32'(bus.out_data), 32'hA5);
        check("perr_flag", 32'(bus.out_perr), 32'd1);
        check("perr_no_ferr", 32'(frame_err), 32'd0);
        idle(2);

        // Bad stop bit.
        send_frame(8'h3C, 1'b0, 1'b1, -1, done);
        goto_edge(done);
        check("ferr_pulse", 32'(frame_err), 32'd1);
        check("ferr_valid", 32'(bus.out_valid), 32'd0);
        check("ferr_busy", 32'(busy), 32'd0);
        idle(1);
        goto_edge(done + 1);
        check("ferr_width", 32'(frame_err), 32'd0);
        idle(2);

        // Overrun: 0x11 held, 0x22 dropped.
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, -1, done);
        idle(1);
        send_frame(8'h22, 1'b0, 1'b0, -1, done);
        goto_edge(done);
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_held", 32'(bus.out_data), 32'h11);
        idle(1);
        goto_edge(done + 1);
        check("ovr_width", 32'(overrun), 32'd0);
        check("ovr_still", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        goto_edge(done + 3);
        check("ovr_drained", 32'(bus.out_valid), 32'd0);
        check("ovr_no22", 32'(bus.out_data), 32'h11);
        idle(1);

        // Drain and load on the same edge.
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, -1, done);
        idle(1);
        send_frame(8'h22, 1'b0, 1'b0, 1, done);
        goto_edge(done);
        check("dl_data", 32'(bus.out_data), 32'h22);
        check("dl_valid", 32'(bus.out_valid), 32'd1);
        check("dl_no_ovr", 32'(overrun), 32'd0);
        idle(2);

        // Reset in the middle of 0xFF with a word buffered.
        out_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, -1, done);
        idle(1);
        @(negedge clk);
        sched_frame(8'hFF, 1'b0, 1'b0, done);
        sin = 1'b1;
        repeat (4) begin
            @(negedge clk);
            sin = 1'b1;
        end
        @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        model_clear();
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_data", 32'(bus.out_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        sin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send_frame(8'h81, 1'b0, 1'b0, -1, done);
        goto_edge(done);
        check("post_rst_data", 32'(bus.out_data), 32'h81);
        check("post_rst_perr", 32'(bus.out_perr), 32'd0);
        idle(2);

        // Random frames with random back-pressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            w    = N'($urandom);
            pbit = ($urandom_range(0, 9) < 7) ? (^w) : ~(^w);
            sbit = ($urandom_range(0, 9) == 0);
            send_frame(w, pbit, sbit, -1, done);
            idle($urandom_range(0, 3));
        end
        idle(1);
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
